control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The block SHALL have these ports:
  clk        input   1  system clock; state advances on rising edge
  reset      input   1  asynchronous, active-low
  run        input   1  1 = sequence advances; 0 = freeze
  opcode     input   4  upper nibble of instruction register
  Cp         output  1  PC increment enable, active-high
  Ep         output  1  PC-to-bus enable, active-high
  Lm_n       output  1  MAR load, active-low
  CE_n       output  1  RAM output enable, active-low
  Li_n       output  1  IR load, active-low
  Ei_n       output  1  IR address-field-to-bus enable, active-low
  La_n       output  1  accumulator load, active-low
  Ea         output  1  accumulator-to-bus enable, active-high
  Su         output  1  ALU subtract select, active-high
  Eu         output  1  ALU-to-bus enable, active-high
  Lb_n       output  1  B register load, active-low
  Lo_n       output  1  output register load, active-low
  halt       output  1  1 = HLT executed, sequencer stopped
  tstate     output  6  one-hot ring state, bit0 = T1 ... bit5 = T6
REQ-002 The reset input SHALL be asynchronous and active-low.

Function
REQ-003 The ring counter SHALL be one-hot over T1..T6, SHALL advance by one state on each rising clk edge when run=1, halt=0 and reset=1, and SHALL wrap from T6 to T1.
REQ-004 Control outputs SHALL be decoded combinationally from tstate and the latched opcode, so they are stable before the falling edge on which PC, MAR and registers act.
REQ-005 The opcode SHALL be latched into an internal register on the rising edge leaving T3, and the latched value SHALL be used for all of T4-T6.
REQ-006 The inactive control word SHALL be Cp=0 Ep=0 Lm_n=1 CE_n=1 Li_n=1 Ei_n=1 La_n=1 Ea=0 Su=0 Eu=0 Lb_n=1 Lo_n=1; any signal not listed for a state SHALL be inactive.
REQ-007 Fetch states, independent of opcode: T1 Ep=1 Lm_n=0; T2 Cp=1; T3 CE_n=0 Li_n=0.
REQ-008 LDA (0000): T4 Ei_n=0 Lm_n=0; T5 CE_n=0 La_n=0; T6 inactive.
REQ-009 ADD (0001): T4 Ei_n=0 Lm_n=0; T5 CE_n=0 Lb_n=0; T6 Eu=1 La_n=0 Su=0.
REQ-010 SUB (0010): identical to ADD, except Su=1 in T6.
REQ-011 OUT (1110): T4 Ea=1 Lo_n=0; T5 and T6 inactive.
REQ-012 HLT (1111): on the rising edge leaving T3, halt SHALL go to 1.
REQ-013 While halt=1, tstate SHALL hold at T4 and all control outputs SHALL be inactive until reset.
REQ-014 Any other opcode SHALL execute as a NOP: T4-T6 all inactive, then normal wrap to T1.
REQ-015 When run=0, tstate and the latched opcode SHALL hold, and all control outputs SHALL be forced inactive.
REQ-016 When run returns to 1, the held state's control word SHALL reappear, and advancing SHALL resume on the next rising edge.
REQ-017 At most one bus driver (Ep, Ei_n active, CE_n active, Ea, Eu) SHALL be active in any state.

Reset
REQ-018 While reset=0, the block SHALL set tstate=000001 (T1), latched opcode=0000 and halt=0, immediately and without waiting for clk.
REQ-019 With reset=0 and run=1, the outputs SHALL show the T1 word (Ep=1, Lm_n=0, all others inactive).
REQ-020 With reset=0 and run=0, all control outputs SHALL be inactive.
REQ-021 Reset asserted mid-instruction, including during halt, SHALL abort the instruction, and the first rising edge after release SHALL move tstate to T2.

Verification
REQ-022 Reset release with run=1 and opcode=0000, six clocks -> tstate sequence 01,02,04,08,10,20,01 (hex); T1 Ep=1 Lm_n=0; T2 Cp=1; T3 CE_n=0 Li_n=0; T4 Ei_n=0 Lm_n=0; T5 CE_n=0 La_n=0.
REQ-023 opcode=0010 held through T3 -> T6 shows Eu=1 La_n=0 Su=1; the same test with 0001 -> Su=0.
REQ-024 opcode=1111 -> halt=1 after the edge leaving T3; tstate stays 08 for 20 clocks with all outputs inactive; reset pulse -> halt=0, tstate=01.
REQ-025 opcode changed from 0001 to 1110 during T5 -> T6 still executes ADD (latched); the next instruction's T4 decodes the new value.
REQ-026 run=0 asserted in T2 for 5 clocks -> tstate stays 02 and Cp=0 throughout; after run=1, Cp=1 for one cycle, then T3.
REQ-027 reset asserted asynchronously mid-T5 of an ADD -> tstate=01 before the next clk edge; Lb_n returns to 1 immediately.

Source files
------------

// File: rtl/control_sequencer.sv
// Six-state ring-counter control sequencer for a SAP-1 style accumulator machine.
// Control outputs are decoded combinationally from the ring state and the latched opcode.
module control_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic [3:0] opcode,
    output logic       Cp,
    output logic       Ep,
    output logic       Lm_n,
    output logic       CE_n,
    output logic       Li_n,
    output logic       Ei_n,
    output logic       La_n,
    output logic       Ea,
    output logic       Su,
    output logic       Eu,
    output logic       Lb_n,
    output logic       Lo_n,
    output logic       halt,
    output logic [5:0] tstate
);

    typedef enum logic [3:0] {
        OP_LDA = 4'h0,
        OP_ADD = 4'h1,
        OP_SUB = 4'h2,
        OP_OUT = 4'hE,
        OP_HLT = 4'hF
    } opcode_t;

    localparam logic [5:0] T1 = 6'b000001;
    localparam logic [5:0] T2 = 6'b000010;
    localparam logic [5:0] T3 = 6'b000100;
    localparam logic [5:0] T4 = 6'b001000;
    localparam logic [5:0] T5 = 6'b010000;
    localparam logic [5:0] T6 = 6'b100000;

    opcode_t opcode_q;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tstate   <= T1;
            opcode_q <= OP_LDA;
            halt     <= 1'b0;
        end else if (run && !halt) begin
            tstate <= {tstate[4:0], tstate[5]};
            // The opcode is captured on the edge leaving T3 and held for the execute states.
            if (tstate[2]) begin
                opcode_q <= opcode_t'(opcode);
                if (opcode == OP_HLT) begin
                    halt <= 1'b1;
                end
            end
        end
    end

    // NOTE: every output gets its inactive value first, so no path through the case infers a latch.
    always_comb begin
        Cp   = 1'b0;
        Ep   = 1'b0;
        Lm_n = 1'b1;
        CE_n = 1'b1;
        Li_n = 1'b1;
        Ei_n = 1'b1;
        La_n = 1'b1;
        Ea   = 1'b0;
        Su   = 1'b0;
        Eu   = 1'b0;
        Lb_n = 1'b1;
        Lo_n = 1'b1;
        if (run && !halt) begin
            case (tstate)
                T1: begin
                    Ep   = 1'b1;
                    Lm_n = 1'b0;
                end
                T2: Cp = 1'b1;
                T3: begin
                    CE_n = 1'b0;
                    Li_n = 1'b0;
                end
                T4: begin
                    case (opcode_q)
                        OP_LDA, OP_ADD, OP_SUB: begin
                            Ei_n = 1'b0;
                            Lm_n = 1'b0;
                        end
                        OP_OUT: begin
                            Ea   = 1'b1;
                            Lo_n = 1'b0;
                        end
                        default: ;
                    endcase
                end
                T5: begin
                    case (opcode_q)
                        OP_LDA: begin
                            CE_n = 1'b0;
                            La_n = 1'b0;
                        end
                        OP_ADD, OP_SUB: begin
                            CE_n = 1'b0;
                            Lb_n = 1'b0;
                        end
                        default: ;
                    endcase
                end
                T6: begin
                    if (opcode_q == OP_ADD || opcode_q == OP_SUB) begin
                        Eu   = 1'b1;
                        La_n = 1'b0;
                        Su   = (opcode_q == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed-vector bench for control_sequencer: stimulus pushes expected responses,
// a separate monitor pops and compares them against the DUT outputs.
module tb_control_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       run = 1'b0;
    logic [3:0] opcode = 4'h0;
    logic       Cp, Ep, Lm_n, CE_n, Li_n, Ei_n, La_n, Ea, Su, Eu, Lb_n, Lo_n, halt;
    logic [5:0] tstate;

    control_sequencer dut (
        .clk(clk), .reset(reset), .run(run), .opcode(opcode),
        .Cp(Cp), .Ep(Ep), .Lm_n(Lm_n), .CE_n(CE_n), .Li_n(Li_n), .Ei_n(Ei_n),
        .La_n(La_n), .Ea(Ea), .Su(Su), .Eu(Eu), .Lb_n(Lb_n), .Lo_n(Lo_n),
        .halt(halt), .tstate(tstate)
    );

    always #5 clk = ~clk;

    localparam logic [5:0] T1 = 6'h01, T2 = 6'h02, T3 = 6'h04;
    localparam logic [5:0] T4 = 6'h08, T5 = 6'h10, T6 = 6'h20;

    // Control word bit order: Cp Ep Lm_n CE_n | Li_n Ei_n La_n Ea | Su Eu Lb_n Lo_n
    localparam logic [11:0] W_IDLE = 12'b0011_1110_0011;
    localparam logic [11:0] W_T1   = 12'b0101_1110_0011;
    localparam logic [11:0] W_T2   = 12'b1011_1110_0011;
    localparam logic [11:0] W_T3   = 12'b0010_0110_0011;
    localparam logic [11:0] W_T4M  = 12'b0001_1010_0011;
    localparam logic [11:0] W_T5L  = 12'b0010_1100_0011;
    localparam logic [11:0] W_T5A  = 12'b0010_1110_0001;
    localparam logic [11:0] W_T6A  = 12'b0011_1100_0111;
    localparam logic [11:0] W_T6S  = 12'b0011_1100_1111;
    localparam logic [11:0] W_T4O  = 12'b0011_1111_0010;

    typedef struct {
        string       name;
        logic [5:0]  ts;
        logic        h;
        logic [11:0] w;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    event probe_ev;

    task automatic check(input string name, input logic [18:0] act, input logic [18:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got tstate=%h halt=%b word=%b, expected tstate=%h halt=%b word=%b",
                     name, act[18:13], act[12], act[11:0], req[18:13], req[12], req[11:0]);
        end
    endtask

    // Monitor: compares whenever a sample point arrives and an expectation is pending.
    initial begin
        exp_t e;
        logic [11:0] w;
        forever begin
            @(negedge clk or probe_ev);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                w = {Cp, Ep, Lm_n, CE_n, Li_n, Ei_n, La_n, Ea, Su, Eu, Lb_n, Lo_n};
                check(e.name, {tstate, halt, w}, {e.ts, e.h, e.w});
            end
        end
    end

    task automatic push(input string name, input logic [5:0] ts, input logic h, input logic [11:0] w);
        exp_t e;
        e.name = name;
        e.ts   = ts;
        e.h    = h;
        e.w    = w;
        exp_q.push_back(e);
    endtask

    // One clock of stimulus: inputs change just after the rising edge, sampled at the falling edge.
    task automatic st(input logic r, input logic rn, input logic [3:0] op,
                      input logic [5:0] ts, input logic h, input logic [11:0] w, input string name);
        @(posedge clk);
        #1;
        reset  = r;
        run    = rn;
        opcode = op;
        push(name, ts, h, w);
    endtask

    initial begin
        // Reset behaviour with and without run
        st(1'b0, 1'b1, 4'h0, T1, 1'b0, W_T1,   "reset_run");
        st(1'b0, 1'b0, 4'h0, T1, 1'b0, W_IDLE, "reset_norun");
        // LDA through a full ring
        st(1'b1, 1'b1, 4'h0, T1, 1'b0, W_T1,   "lda_t1");
        st(1'b1, 1'b1, 4'h0, T2, 1'b0, W_T2,   "lda_t2");
        st(1'b1, 1'b1, 4'h0, T3, 1'b0, W_T3,   "lda_t3");
        st(1'b1, 1'b1, 4'h0, T4, 1'b0, W_T4M,  "lda_t4");
        st(1'b1, 1'b1, 4'h0, T5, 1'b0, W_T5L,  "lda_t5");
        st(1'b1, 1'b1, 4'h0, T6, 1'b0, W_IDLE, "lda_t6");
        st(1'b1, 1'b1, 4'h0, T1, 1'b0, W_T1,   "lda_wrap");
        // ADD
        st(1'b1, 1'b1, 4'h1, T2, 1'b0, W_T2,   "add_t2");
        st(1'b1, 1'b1, 4'h1, T3, 1'b0, W_T3,   "add_t3");
        st(1'b1, 1'b1, 4'h1, T4, 1'b0, W_T4M,  "add_t4");
        st(1'b1, 1'b1, 4'h1, T5, 1'b0, W_T5A,  "add_t5");
        st(1'b1, 1'b1, 4'h1, T6, 1'b0, W_T6A,  "add_t6");
        st(1'b1, 1'b1, 4'h1, T1, 1'b0, W_T1,   "add_wrap");
        // SUB
        st(1'b1, 1'b1, 4'h2, T2, 1'b0, W_T2,   "sub_t2");
        st(1'b1, 1'b1, 4'h2, T3, 1'b0, W_T3,   "sub_t3");
        st(1'b1, 1'b1, 4'h2, T4, 1'b0, W_T4M,  "sub_t4");
        st(1'b1, 1'b1, 4'h2, T5, 1'b0, W_T5A,  "sub_t5");
        st(1'b1, 1'b1, 4'h2, T6, 1'b0, W_T6S,  "sub_t6");
        st(1'b1, 1'b1, 4'h2, T1, 1'b0, W_T1,   "sub_wrap");
        // ADD latched, opcode changes to OUT during T5; next instruction is OUT
        st(1'b1, 1'b1, 4'h1, T2, 1'b0, W_T2,   "latch_t2");
        st(1'b1, 1'b1, 4'h1, T3, 1'b0, W_T3,   "latch_t3");
        st(1'b1, 1'b1, 4'h1, T4, 1'b0, W_T4M,  "latch_t4");
        st(1'b1, 1'b1, 4'hE, T5, 1'b0, W_T5A,  "latch_t5");
        st(1'b1, 1'b1, 4'hE, T6, 1'b0, W_T6A,  "latch_t6");
        st(1'b1, 1'b1, 4'hE, T1, 1'b0, W_T1,   "out_t1");
        st(1'b1, 1'b1, 4'hE, T2, 1'b0, W_T2,   "out_t2");
        st(1'b1, 1'b1, 4'hE, T3, 1'b0, W_T3,   "out_t3");
        st(1'b1, 1'b1, 4'hE, T4, 1'b0, W_T4O,  "out_t4");
        st(1'b1, 1'b1, 4'hE, T5, 1'b0, W_IDLE, "out_t5");
        st(1'b1, 1'b1, 4'hE, T6, 1'b0, W_IDLE, "out_t6");
        st(1'b1, 1'b1, 4'hE, T1, 1'b0, W_T1,   "out_wrap");
        // Unassigned opcode runs as NOP
        st(1'b1, 1'b1, 4'h5, T2, 1'b0, W_T2,   "nop_t2");
        st(1'b1, 1'b1, 4'h5, T3, 1'b0, W_T3,   "nop_t3");
        st(1'b1, 1'b1, 4'h5, T4, 1'b0, W_IDLE, "nop_t4");
        st(1'b1, 1'b1, 4'h5, T5, 1'b0, W_IDLE, "nop_t5");
        st(1'b1, 1'b1, 4'h5, T6, 1'b0, W_IDLE, "nop_t6");
        st(1'b1, 1'b1, 4'h5, T1, 1'b0, W_T1,   "nop_wrap");
        // Freeze in T2 for five clocks, then resume
        for (int i = 0; i < 5; i++) begin
            st(1'b1, 1'b0, 4'h1, T2, 1'b0, W_IDLE, "freeze_t2");
        end
        st(1'b1, 1'b1, 4'h1, T2, 1'b0, W_T2,   "resume_t2");
        st(1'b1, 1'b1, 4'h1, T3, 1'b0, W_T3,   "resume_t3");
        st(1'b1, 1'b1, 4'h1, T4, 1'b0, W_T4M,  "abort_t4");
        // Asynchronous reset in the middle of an ADD's T5
        @(posedge clk);
        #1;
        reset  = 1'b1;
        run    = 1'b1;
        opcode = 4'h1;
        push("abort_t5", T5, 1'b0, W_T5A);
        #6;
        reset = 1'b0;
        push("abort_async", T1, 1'b0, W_T1);
        #1;
        ->probe_ev;
        st(1'b1, 1'b1, 4'h1, T1, 1'b0, W_T1,   "abort_release");
        st(1'b1, 1'b1, 4'hF, T2, 1'b0, W_T2,   "abort_first_edge");
        // HLT: stops in T4 with everything inactive until reset
        st(1'b1, 1'b1, 4'hF, T3, 1'b0, W_T3,   "hlt_t3");
        st(1'b1, 1'b1, 4'hF, T4, 1'b1, W_IDLE, "hlt_enter");
        for (int i = 0; i < 20; i++) begin
            st(1'b1, 1'b1, 4'hF, T4, 1'b1, W_IDLE, "hlt_hold");
        end
        st(1'b0, 1'b1, 4'hF, T1, 1'b0, W_T1,   "hlt_reset");
        st(1'b1, 1'b1, 4'h0, T1, 1'b0, W_T1,   "hlt_release");
        st(1'b1, 1'b1, 4'h0, T2, 1'b0, W_T2,   "hlt_restart");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations still pending, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
